// File: rtl/adder_meas_pkg.sv
// adder_meas_pkg: state encoding and default timing constants shared by the measurement sequencer
package adder_meas_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DRAIN, CAPTURE, DONE} state_t;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_DRAIN_CYCLES = 2;
endpackage

// File: rtl/meas_down_counter.sv
// meas_down_counter: loadable down-counter with zero flag, shared by the settle/run/drain phases
module meas_down_counter #(
    parameter int WIDTH = adder_meas_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);
    logic [WIDTH-1:0] count;
    assign zero = (count == '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (load) count <= value;
        else if (enable && !zero) count <= count - 1'b1;
    end
endmodule

// File: rtl/adder_measure_sequencer.sv
// adder_measure_sequencer: applies operands to the instrumented adder, gates its ring oscillator
// for a programmed number of cycles, then captures ring count and sum for readback
module adder_measure_sequencer
    import adder_meas_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES
) (
    input  logic             wb_clk_i,
    input  logic             reset_n,
    input  logic             active,
    input  logic [WIDTH-1:0] cfg_a,
    input  logic [WIDTH-1:0] cfg_b,
    input  logic [WIDTH-1:0] cfg_window,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             ring_en,
    output logic             counter_en,
    output logic             counter_clear,
    input  logic [WIDTH-1:0] ring_count,
    input  logic [WIDTH-1:0] adder_sum,
    output logic [WIDTH-1:0] result_count,
    output logic [WIDTH-1:0] result_sum,
    output logic             busy,
    output logic             done
);
    state_t state, next_state;
    logic start_q, zero, cnt_load, cnt_en, stop, launch;
    logic [WIDTH-1:0] win_q, cnt_value;
    assign stop   = abort | ~active;
    assign launch = (state == IDLE) & start & ~start_q & ~stop;
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = launch ? LOAD : IDLE;
            LOAD:    next_state = SETTLE;
            SETTLE:  next_state = zero ? RUN : SETTLE;
            RUN:     next_state = zero ? DRAIN : RUN;
            DRAIN:   next_state = zero ? CAPTURE : DRAIN;
            CAPTURE: next_state = DONE;
            DONE:    next_state = start ? DONE : IDLE;
            default: next_state = IDLE;
        endcase
        if (stop) next_state = IDLE;
    end
    // The counter holds "cycles remaining minus one", so each phase ends on the zero flag.
    always_comb begin
        ring_en       = (state == RUN) & ~stop;
        counter_en    = ring_en;
        counter_clear = (state == LOAD) & active;
        busy          = active & (state != IDLE) & (state != DONE);
        done          = active & (state == DONE);
        cnt_load      = (state == LOAD) | (zero & ((state == SETTLE) | (state == RUN)));
        cnt_en        = (state == SETTLE) | (state == RUN) | (state == DRAIN);
        cnt_value     = (state == LOAD)   ? WIDTH'(SETTLE_CYCLES - 1) :
                        (state == SETTLE) ? ((win_q == '0) ? '0 : win_q - 1'b1) :
                                            WIDTH'(DRAIN_CYCLES - 1);
    end
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            start_q      <= 1'b0;
            win_q        <= '0;
            adder_a      <= '0;
            adder_b      <= '0;
            result_count <= '0;
            result_sum   <= '0;
        end else begin
            start_q <= start;
            if (!active) begin
                adder_a      <= '0;
                adder_b      <= '0;
                result_count <= '0;
                result_sum   <= '0;
            end else begin
                if (launch) begin
                    adder_a <= cfg_a;
                    adder_b <= cfg_b;
                    win_q   <= cfg_window;
                end
                if (state == CAPTURE && !abort) begin
                    result_count <= ring_count;
                    result_sum   <= adder_sum;
                end
            end
        end
    end
    meas_down_counter #(.WIDTH(WIDTH)) u_counter (
        .clk    (wb_clk_i),
        .rst_n  (reset_n),
        .load   (cnt_load),
        .enable (cnt_en),
        .value  (cnt_value),
        .zero   (zero)
    );
endmodule

// File: tb/tb_adder_measure_sequencer.sv
// tb_adder_measure_sequencer: randomized scenario bench with a behavioural adder/ring model
module tb_adder_measure_sequencer;
    localparam int W = 32;
    localparam int SETTLE = 2;
    localparam int DRAIN = 2;
    logic wb_clk_i = 1'b0;
    logic reset_n = 1'b0;
    logic active = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [W-1:0] cfg_a = '0, cfg_b = '0, cfg_window = '0;
    logic [W-1:0] adder_a, adder_b, ring_count, adder_sum, result_count, result_sum;
    logic ring_en, counter_en, counter_clear, busy, done;
    logic [W-1:0] step = 1;
    logic [W-1:0] last_count = '0, last_sum = '0;
    int errors = 0;
    int checks = 0;

    adder_measure_sequencer dut (
        .wb_clk_i      (wb_clk_i),
        .reset_n       (reset_n),
        .active        (active),
        .cfg_a         (cfg_a),
        .cfg_b         (cfg_b),
        .cfg_window    (cfg_window),
        .start         (start),
        .abort         (abort),
        .adder_a       (adder_a),
        .adder_b       (adder_b),
        .ring_en       (ring_en),
        .counter_en    (counter_en),
        .counter_clear (counter_clear),
        .ring_count    (ring_count),
        .adder_sum     (adder_sum),
        .result_count  (result_count),
        .result_sum    (result_sum),
        .busy          (busy),
        .done          (done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Environment: combinational adder and a ring counter advancing by `step` per enabled cycle
    assign adder_sum = adder_a + adder_b;
    always @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) ring_count <= '0;
        else if (counter_clear) ring_count <= '0;
        else if (counter_en) ring_count <= ring_count + step;
    end

    function automatic int eff_win(input logic [W-1:0] win);
        return (win == 0) ? 1 : int'(win);
    endfunction

    // edges after the launch edge until done is first seen
    function automatic int exp_lat(input logic [W-1:0] win);
        return 1 + SETTLE + eff_win(win) + DRAIN + 1;
    endfunction

    task automatic launch_run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] win,
                              output int lat, output int rings, output int clears, output int en_diff);
        @(negedge wb_clk_i);
        cfg_a = a; cfg_b = b; cfg_window = win; start = 1'b1;
        lat = -1; rings = 0; clears = 0; en_diff = 0;
        for (int k = 1; k <= 300 && lat < 0; k++) begin
            @(negedge wb_clk_i);
            if (ring_en) rings++;
            if (counter_en !== ring_en) en_diff++;
            if (counter_clear) clears++;
            if (done) lat = k - 1;
            cfg_a = $urandom; cfg_b = $urandom; cfg_window = $urandom;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        checks++; if ({ring_en, counter_en, counter_clear, busy, done} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b want=00000", {ring_en, counter_en, counter_clear, busy, done}); end
        checks++; if ({adder_a, adder_b} !== '0) begin errors++; $display("FAIL reset_operands got=%h want=0", {adder_a, adder_b}); end
        checks++; if ({result_count, result_sum} !== '0) begin errors++; $display("FAIL reset_results got=%h want=0", {result_count, result_sum}); end
        reset_n = 1'b1;
        @(negedge wb_clk_i);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got=%b want=0", busy); end
    endtask

    task automatic test_basic;
        int lat, rings, clears, en_diff;
        step = 3;
        launch_run(5, 7, 10, lat, rings, clears, en_diff);
        checks++; if (lat !== 16) begin errors++; $display("FAIL basic_latency got=%0d want=16", lat); end
        checks++; if (rings !== 10) begin errors++; $display("FAIL basic_ring_cycles got=%0d want=10", rings); end
        checks++; if (clears !== 1) begin errors++; $display("FAIL basic_clear_pulses got=%0d want=1", clears); end
        checks++; if (en_diff !== 0) begin errors++; $display("FAIL basic_counter_en_tracks got=%0d want=0", en_diff); end
        checks++; if (result_sum !== 32'd12) begin errors++; $display("FAIL basic_sum got=%0d want=12", result_sum); end
        checks++; if (result_count !== 32'd30) begin errors++; $display("FAIL basic_count got=%0d want=30", result_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got=%b want=0", busy); end
        start = 1'b0;
        @(negedge wb_clk_i);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_clears got=%b want=0", done); end
        last_count = 30; last_sum = 12;
    endtask

    task automatic test_window_zero;
        int lat, rings, clears, en_diff;
        logic [W-1:0] a, b;
        a = $urandom; b = $urandom; step = $urandom_range(1, 9);
        launch_run(a, b, 0, lat, rings, clears, en_diff);
        checks++; if (lat !== 7) begin errors++; $display("FAIL win0_latency got=%0d want=7", lat); end
        checks++; if (rings !== 1) begin errors++; $display("FAIL win0_ring_cycles got=%0d want=1", rings); end
        checks++; if (result_sum !== a + b) begin errors++; $display("FAIL win0_sum got=%h want=%h", result_sum, a + b); end
        checks++; if (result_count !== step) begin errors++; $display("FAIL win0_count got=%0d want=%0d", result_count, step); end
        start = 1'b0;
        @(negedge wb_clk_i);
        last_count = step; last_sum = a + b;
    endtask

    task automatic test_random;
        int lat, rings, clears, en_diff;
        logic [W-1:0] a, b, win, exp_c;
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; win = $urandom_range(1, 20); step = $urandom_range(1, 1000);
            exp_c = step * W'(eff_win(win));
            launch_run(a, b, win, lat, rings, clears, en_diff);
            checks++; if (lat !== exp_lat(win)) begin errors++; $display("FAIL rand%0d_latency got=%0d want=%0d", i, lat, exp_lat(win)); end
            checks++; if (rings !== eff_win(win)) begin errors++; $display("FAIL rand%0d_ring_cycles got=%0d want=%0d", i, rings, eff_win(win)); end
            checks++; if (result_sum !== a + b) begin errors++; $display("FAIL rand%0d_sum got=%h want=%h", i, result_sum, a + b); end
            checks++; if (result_count !== exp_c) begin errors++; $display("FAIL rand%0d_count got=%0d want=%0d", i, result_count, exp_c); end
            start = 1'b0;
            @(negedge wb_clk_i);
            last_count = exp_c; last_sum = a + b;
        end
    endtask

    task automatic test_abort;
        int n;
        n = 0;
        step = 5;
        @(negedge wb_clk_i);
        cfg_a = $urandom; cfg_b = $urandom; cfg_window = 10; start = 1'b1;
        for (int k = 0; k < 100 && n < 2; k++) begin
            @(negedge wb_clk_i);
            if (ring_en) n++;
        end
        @(negedge wb_clk_i);
        checks++; if (ring_en !== 1'b1) begin errors++; $display("FAIL abort_run3_enabled got=%b want=1", ring_en); end
        abort = 1'b1;
        #1;
        checks++; if ({ring_en, counter_en} !== 2'b00) begin errors++; $display("FAIL abort_gates_ring got=%b want=00", {ring_en, counter_en}); end
        @(negedge wb_clk_i);
        abort = 1'b0; start = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_idle got=%b want=00", {busy, done}); end
        checks++; if (result_count !== last_count) begin errors++; $display("FAIL abort_count_kept got=%0d want=%0d", result_count, last_count); end
        checks++; if (result_sum !== last_sum) begin errors++; $display("FAIL abort_sum_kept got=%h want=%h", result_sum, last_sum); end
        @(negedge wb_clk_i);
    endtask

    task automatic test_hold_start;
        int lat, rings, clears, en_diff, extra;
        logic [W-1:0] a, b;
        extra = 0;
        a = $urandom; b = $urandom; step = 2;
        launch_run(a, b, 3, lat, rings, clears, en_diff);
        checks++; if (lat !== exp_lat(3)) begin errors++; $display("FAIL hold_latency got=%0d want=%0d", lat, exp_lat(3)); end
        repeat (6) begin
            @(negedge wb_clk_i);
            if (ring_en || busy) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL hold_relaunch got=%0d want=0", extra); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done_held got=%b want=1", done); end
        start = 1'b0;
        @(negedge wb_clk_i);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_drop_idle got=%b want=0", done); end
        a = $urandom; b = $urandom; step = 4;
        launch_run(a, b, 6, lat, rings, clears, en_diff);
        checks++; if (result_sum !== a + b) begin errors++; $display("FAIL hold_second_sum got=%h want=%h", result_sum, a + b); end
        checks++; if (result_count !== 32'd24) begin errors++; $display("FAIL hold_second_count got=%0d want=24", result_count); end
        start = 1'b0;
        @(negedge wb_clk_i);
        last_count = 24; last_sum = a + b;
    endtask

    task automatic test_reset_mid_run;
        int n;
        n = 0;
        @(negedge wb_clk_i);
        cfg_a = $urandom | 1; cfg_b = $urandom; cfg_window = 8; start = 1'b1;
        for (int k = 0; k < 100 && n < 2; k++) begin
            @(negedge wb_clk_i);
            if (ring_en) n++;
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL rst_reach_run got=%0d want=2", n); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({ring_en, counter_en, busy, done} !== 4'b0) begin errors++; $display("FAIL rst_async_ctrl got=%b want=0000", {ring_en, counter_en, busy, done}); end
        checks++; if ({adder_a, result_count, result_sum} !== '0) begin errors++; $display("FAIL rst_async_data got=%h want=0", {adder_a, result_count, result_sum}); end
        @(negedge wb_clk_i);
        reset_n = 1'b1; start = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        checks++; if ({busy, done, ring_en} !== 3'b000) begin errors++; $display("FAIL rst_idle_after got=%b want=000", {busy, done, ring_en}); end
        last_count = 0; last_sum = 0;
    endtask

    task automatic test_active;
        int en_seen;
        en_seen = 0;
        step = 7;
        launch_run($urandom, $urandom, 4, en_seen, en_seen, en_seen, en_seen);
        start = 1'b0;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        cfg_a = $urandom | 1; cfg_b = $urandom; cfg_window = 5; start = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL act_in_settle got=%b want=1", busy); end
        en_seen = 0;
        active = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL act_busy_drop got=%b want=0", busy); end
        repeat (8) begin
            @(negedge wb_clk_i);
            if (counter_en || ring_en) en_seen++;
        end
        checks++; if (en_seen !== 0) begin errors++; $display("FAIL act_counter_enabled got=%0d want=0", en_seen); end
        checks++; if ({adder_a, adder_b} !== '0) begin errors++; $display("FAIL act_adder_cleared got=%h want=0", {adder_a, adder_b}); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL act_done got=%b want=0", done); end
        checks++; if ({result_count, result_sum} !== '0) begin errors++; $display("FAIL act_results_cleared got=%h want=0", {result_count, result_sum}); end
        start = 1'b0;
        @(negedge wb_clk_i);
        active = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL act_idle_after got=%b want=0", busy); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_window_zero;
        test_random;
        test_abort;
        test_hold_start;
        test_reset_mid_run;
        test_active;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
